// File: rtl/uart_boot_loader.sv
// UART firmware loader: packs RX bytes little-endian into words, writes them to instruction RAM, then answers ACK/NAK.
// Each full word is issued the cycle after its 4th byte; during a memory stall one byte is buffered and a second is dropped with an error.
module uart_boot_loader #(
  parameter int          ADDR_WIDTH     = 12,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 500_000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  programmer_mode_i,
  input  logic                  rx_received_i,
  input  logic [7:0]            rx_data_i,
  output logic                  tx_start_o,
  output logic [7:0]            tx_data_o,
  input  logic                  tx_sent_i,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_wstrb_o,
  input  logic                  mem_ready_i,
  output logic                  core_resetn_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH:0]   word_count_o
);
  localparam int                TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] CAP    = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {IDLE, RECV, WRITE, REPORT, DONE} state_t;

  state_t        state_q;
  logic [1:0]    byte_idx_q;
  logic [31:0]   buf_q, buf_d;
  logic [TW-1:0] tmo_q;
  logic          seen_q, hold_vld_q, final_q;
  logic [7:0]    hold_dat_q;
  logic [2:0]    cnt_d;
  logic          got_byte, err_d;
  logic [3:0]    part_strb;

  // A held byte always lands in lane 0 because it is only merged right after a full word.
  always_comb begin
    buf_d    = buf_q;
    cnt_d    = {1'b0, byte_idx_q};
    got_byte = 1'b0;
    if (hold_vld_q) begin
      buf_d[7:0] = hold_dat_q;
      cnt_d      = 3'd1;
      got_byte   = 1'b1;
    end
    if (rx_received_i) begin
      buf_d[{cnt_d[1:0], 3'b000} +: 8] = rx_data_i;
      cnt_d    = cnt_d + 3'd1;
      got_byte = 1'b1;
    end
    case (byte_idx_q)
      2'd1:    part_strb = 4'b0001;
      2'd2:    part_strb = 4'b0011;
      2'd3:    part_strb = 4'b0111;
      default: part_strb = 4'b0000;
    endcase
    err_d = error_o | ((state_q == WRITE) && rx_received_i && hold_vld_q);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;       byte_idx_q <= 2'd0;   buf_q <= 32'd0;
      tmo_q <= '0;           seen_q <= 1'b0;       final_q <= 1'b0;
      hold_vld_q <= 1'b0;    hold_dat_q <= 8'd0;
      tx_start_o <= 1'b0;    tx_data_o <= 8'd0;
      mem_we_o <= 1'b0;      mem_addr_o <= BASE_ADDR;
      mem_wdata_o <= 32'd0;  mem_wstrb_o <= 4'd0;
      core_resetn_o <= 1'b0; busy_o <= 1'b0;       done_o <= 1'b0;
      error_o <= 1'b0;       word_count_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (programmer_mode_i) begin
            state_q <= RECV;       byte_idx_q <= 2'd0;  buf_q <= 32'd0;
            tmo_q <= '0;           seen_q <= 1'b0;      hold_vld_q <= 1'b0;
            final_q <= 1'b0;       word_count_o <= '0;  error_o <= 1'b0;
            mem_addr_o <= BASE_ADDR;
            core_resetn_o <= 1'b0; busy_o <= 1'b1;
          end else begin
            core_resetn_o <= ~error_o;
          end
        end
        RECV: begin
          hold_vld_q <= 1'b0;
          if (got_byte) begin
            tmo_q  <= '0;
            seen_q <= 1'b1;
          end else if (seen_q) begin
            tmo_q <= tmo_q + TW'(1);
          end
          if (cnt_d == 3'd4) begin
            byte_idx_q <= 2'd0;
            buf_q      <= 32'd0;
            if (word_count_o == CAP) begin
              error_o <= 1'b1; state_q <= REPORT; tx_start_o <= 1'b1; tx_data_o <= NAK_BYTE;
            end else begin
              state_q <= WRITE; mem_we_o <= 1'b1; mem_wdata_o <= buf_d;
              mem_wstrb_o <= 4'hF; final_q <= 1'b0;
            end
          end else if (got_byte) begin
            byte_idx_q <= cnt_d[1:0];
            buf_q      <= buf_d;
          end else if (!programmer_mode_i || (seen_q && tmo_q == TMO_LAST)) begin
            if (!seen_q) begin
              state_q <= IDLE; busy_o <= 1'b0;
            end else if (byte_idx_q != 2'd0 && word_count_o != CAP) begin
              state_q <= WRITE; mem_we_o <= 1'b1; mem_wdata_o <= buf_q;
              mem_wstrb_o <= part_strb; final_q <= 1'b1;
            end else begin
              // A leftover partial word with no room left is an overflow as well.
              state_q <= REPORT; tx_start_o <= 1'b1;
              error_o <= error_o | (byte_idx_q != 2'd0);
              tx_data_o <= (error_o || byte_idx_q != 2'd0) ? NAK_BYTE : ACK_BYTE;
            end
          end
        end
        WRITE: begin
          if (rx_received_i) begin
            tmo_q  <= '0;
            seen_q <= 1'b1;
            if (hold_vld_q) begin
              error_o <= 1'b1;
            end else begin
              hold_vld_q <= 1'b1;
              hold_dat_q <= rx_data_i;
            end
          end
          if (mem_ready_i) begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= mem_addr_o + 32'd4;
            if (word_count_o != CAP) word_count_o <= word_count_o + (ADDR_WIDTH+1)'(1);
            if (final_q) begin
              state_q <= REPORT; tx_start_o <= 1'b1;
              tx_data_o <= err_d ? NAK_BYTE : ACK_BYTE;
            end else begin
              state_q <= RECV;
            end
          end
        end
        REPORT: begin
          if (tx_sent_i) begin
            tx_start_o <= 1'b0; state_q <= DONE; done_o <= 1'b1;
            busy_o <= 1'b0;     core_resetn_o <= ~error_o;
          end
        end
        DONE: begin
          core_resetn_o <= ~error_o;
          if (!programmer_mode_i) begin
            state_q <= IDLE;
            done_o  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed and random download sessions checked against a byte-chunking reference model.
module tb_uart_boot_loader;
  localparam int          AW   = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          TMO  = 40;
  localparam int          CAP  = 1 << AW;

  logic        aclk = 1'b0, aresetn = 1'b0;
  logic        programmer_mode_i = 1'b0, rx_received_i = 1'b0;
  logic [7:0]  rx_data_i = 8'd0;
  logic        tx_sent_i = 1'b0, mem_ready_i = 1'b0;
  logic        tx_start_o, mem_we_o, core_resetn_o, busy_o, done_o, error_o;
  logic [7:0]  tx_data_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [AW:0] word_count_o;

  always #5 aclk = ~aclk;

  uart_boot_loader #(
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO),
    .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .programmer_mode_i(programmer_mode_i),
    .rx_received_i(rx_received_i), .rx_data_i(rx_data_i),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_sent_i(tx_sent_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i),
    .core_resetn_o(core_resetn_o), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .word_count_o(word_count_o)
  );

  int          n_checks = 0, n_pass = 0;
  int          rdy_policy = 0, rdy_zs = 0;
  int          tx_rises = 0, wr_base = 0, tx_base = 0;
  logic        tx_start_prev = 1'b0;
  logic [67:0] wq[$];
  logic [7:0]  txq[$];
  logic [7:0]  sess_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Memory ready: 0 = always ready, 1 = random with at most 3 stalled cycles, 2 = stalled.
  always begin
    @(posedge aclk); #1;
    if (rdy_policy == 0) mem_ready_i = 1'b1;
    else if (rdy_policy == 1) begin
      if (rdy_zs >= 3 || $urandom_range(0, 1) == 1) begin mem_ready_i = 1'b1; rdy_zs = 0; end
      else begin mem_ready_i = 1'b0; rdy_zs++; end
    end else mem_ready_i = 1'b0;
  end

  always begin
    @(negedge aclk);
    if (tx_start_o) begin
      repeat ($urandom_range(1, 4)) @(posedge aclk);
      #1 tx_sent_i = 1'b1;
      @(posedge aclk); #1 tx_sent_i = 1'b0;
    end
  end

  always @(negedge aclk) begin
    if (aresetn && mem_we_o && mem_ready_i) wq.push_back({mem_addr_o, mem_wdata_o, mem_wstrb_o});
    if (aresetn && tx_start_o && tx_sent_i) txq.push_back(tx_data_o);
    if (tx_start_o && !tx_start_prev) tx_rises++;
    tx_start_prev = tx_start_o;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired: simulation did not complete");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_received_i = 1'b1; rx_data_i = b;
    tick(1);
    rx_received_i = 1'b0;
    tick(gap);
  endtask

  task automatic start_session();
    wr_base = wq.size(); tx_base = txq.size();
    programmer_mode_i = 1'b1;
    tick(2);
  endtask

  // Reference: the session's bytes chunked little-endian into words, capped at CAP words.
  task automatic end_session(input string tag, input bit by_timeout, input bit extra_err);
    int n, nw, nfull, exp_n;
    bit ovf, err;
    logic [31:0] w;
    logic [3:0]  s;
    logic [67:0] got;
    if (!by_timeout) programmer_mode_i = 1'b0;
    for (int i = 0; i < 400 && txq.size() == tx_base; i++) tick(1);
    tick(1);
    n = sess_q.size(); nw = n / 4; ovf = nw > CAP; err = ovf | extra_err;
    nfull = ovf ? CAP : nw;
    exp_n = nfull + ((!ovf && (n % 4) != 0) ? 1 : 0);
    check({tag, "_tx_count"}, txq.size() - tx_base, 1);
    if (txq.size() > tx_base) check({tag, "_tx_byte"}, txq[tx_base], err ? 8'h15 : 8'h06);
    check({tag, "_nwrites"}, wq.size() - wr_base, exp_n);
    for (int k = 0; k < exp_n; k++) begin
      w = 32'd0; s = 4'd0;
      for (int b = 0; b < 4; b++)
        if (4 * k + b < n) begin w[8*b +: 8] = sess_q[4*k+b]; s[b] = 1'b1; end
      if (wr_base + k < wq.size()) begin
        got = wq[wr_base+k];
        check($sformatf("%s_w%0d_addr", tag, k), got[67:36], BASE + 32'(4 * k));
        check($sformatf("%s_w%0d_data", tag, k), got[35:4], w);
        check($sformatf("%s_w%0d_strb", tag, k), got[3:0], s);
      end
    end
    check({tag, "_error"}, error_o, err);
    check({tag, "_word_count"}, word_count_o, exp_n);
    if (by_timeout) begin
      check({tag, "_done"}, done_o, 1);
      check({tag, "_core_rst_done"}, core_resetn_o, !err);
      programmer_mode_i = 1'b0;
    end
    tick(2);
    check({tag, "_idle_busy"}, busy_o, 0);
    check({tag, "_idle_done"}, done_o, 0);
    check({tag, "_idle_core_rst"}, core_resetn_o, !err);
  endtask

  initial begin
    int bad, r, n;
    tick(3);
    check("rst_mem_we", mem_we_o, 0);
    check("rst_tx_start", tx_start_o, 0);
    check("rst_core_resetn", core_resetn_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_word_count", word_count_o, 0);
    check("rst_mem_addr", mem_addr_o, BASE);
    aresetn = 1'b1;
    tick(2);
    check("release_core", core_resetn_o, 1);

    rdy_policy = 0;
    sess_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    start_session();
    foreach (sess_q[i]) send_byte(sess_q[i], $urandom_range(6, 12));
    end_session("two_words", 1, 0);

    sess_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    start_session();
    foreach (sess_q[i]) send_byte(sess_q[i], $urandom_range(6, 12));
    end_session("partial", 0, 0);

    rdy_policy = 2;
    sess_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    start_session();
    for (int i = 0; i < 4; i++) send_byte(sess_q[i], 6);
    check("stall_we", mem_we_o, 1);
    send_byte(8'hAA, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (mem_we_o !== 1'b1 || mem_addr_o !== BASE || mem_wdata_o !== 32'h0403_0201 ||
          mem_wstrb_o !== 4'hF) bad++;
    end
    check("stall_stable", bad, 0);
    check("stall_one_held_ok", error_o, 0);
    rdy_policy = 0;
    tick(3);
    for (int i = 5; i < 8; i++) send_byte(sess_q[i], 6);
    end_session("stall_hold", 0, 0);

    rdy_policy = 2;
    sess_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hE1};
    start_session();
    for (int i = 0; i < 4; i++) send_byte(sess_q[i], 6);
    send_byte(8'hE1, 2);
    check("hold1_no_err", error_o, 0);
    send_byte(8'hE2, 2);
    check("hold2_err", error_o, 1);
    rdy_policy = 0;
    tick(4);
    end_session("hold_overrun", 0, 1);

    sess_q.delete();
    for (int i = 0; i < 20; i++) sess_q.push_back(8'($urandom));
    start_session();
    foreach (sess_q[i]) send_byte(sess_q[i], 6);
    end_session("overflow", 1, 0);

    rdy_policy = 2;
    start_session();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 6);
    check("rstw_we_before", mem_we_o, 1);
    aresetn = 1'b0; programmer_mode_i = 1'b0;
    tick(1);
    check("rstw_mem_we", mem_we_o, 0);
    check("rstw_busy", busy_o, 0);
    check("rstw_done", done_o, 0);
    check("rstw_error", error_o, 0);
    check("rstw_tx_start", tx_start_o, 0);
    check("rstw_core_resetn", core_resetn_o, 0);
    check("rstw_mem_addr", mem_addr_o, BASE);
    check("rstw_word_count", word_count_o, 0);
    aresetn = 1'b1; rdy_policy = 0;
    tick(2);
    check("rstw_core_release", core_resetn_o, 1);

    r = tx_rises;
    start_session();
    check("empty_busy", busy_o, 1);
    check("empty_core_held", core_resetn_o, 0);
    programmer_mode_i = 1'b0;
    tick(3);
    check("empty_idle", busy_o, 0);
    check("empty_no_tx", tx_rises, r);
    check("empty_core", core_resetn_o, 1);

    rdy_policy = 1;
    for (int s = 0; s < 5; s++) begin
      n = $urandom_range(1, 16);
      sess_q.delete();
      for (int i = 0; i < n; i++) sess_q.push_back(8'($urandom));
      start_session();
      foreach (sess_q[i]) send_byte(sess_q[i], $urandom_range(6, 12));
      end_session($sformatf("rand%0d", s), $urandom_range(0, 1) == 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
